// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync-FIFO write port among NUM_REQ producers.
// Each grant carries at most MAX_BURST words and throttles on full/almostfull.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            accept,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_overflow,
    output logic [7:0]                    ovf_cnt,
    output logic                          busy
);

    localparam int          PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NR = NUM_REQ;

    typedef enum logic [1:0] {IDLE, BURST, STALL} state_t;

    state_t                  state;
    logic [PW-1:0]           rr_ptr;
    logic [PW-1:0]           cur;
    logic [3:0]              burst_cnt;
    logic [PW-1:0]           win_idx;
    logic                    win_found;
    logic [PW-1:0]           next_ptr;
    logic                    stall_cond;
    logic                    cur_req;
    logic                    take;
    logic [FIFO_WIDTH-1:0]   slice [NUM_REQ];
    int unsigned             idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign slice[g] = req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
    end

    // The registered wr_en lags accept by one cycle, so a write already in
    // flight must count against almostfull.
    assign stall_cond = fifo_full | (fifo_almostfull & fifo_wr_en);
    assign cur_req    = req[cur];
    assign take       = (state == BURST) & gnt[cur] & cur_req & ~stall_cond;
    assign next_ptr   = (32'(cur) == NR - 1) ? '0 : cur + PW'(1);
    assign busy       = (state != IDLE);

    always_comb begin
        accept      = '0;
        accept[cur] = take;
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int unsigned off = 0; off < NR; off++) begin
            idx = 32'(rr_ptr) + off;
            if (idx >= NR) idx = idx - NR;
            if (!win_found && req[PW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            gnt          <= '0;
            cur          <= '0;
            rr_ptr       <= '0;
            burst_cnt    <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            ovf_cnt      <= '0;
        end else begin
            if (fifo_overflow && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
            fifo_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt       <= NUM_REQ'(1) << win_idx;
                        cur       <= win_idx;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (take) begin
                        fifo_wr_en   <= 1'b1;
                        fifo_data_in <= slice[cur];
                        burst_cnt    <= burst_cnt + 4'd1;
                        if (burst_cnt == 4'(MAX_BURST - 1)) begin
                            gnt    <= '0;
                            rr_ptr <= next_ptr;
                            state  <= IDLE;
                        end
                    end else if (!cur_req) begin
                        gnt    <= '0;
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end else begin
                        state <= STALL;
                    end
                end
                STALL: begin
                    if (!cur_req) begin
                        gnt    <= '0;
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end else if (!stall_cond) begin
                        state <= BURST;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter: producer model, write and
// grant logs compared against hand-computed sequences.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MB = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     gnt;
    logic [N-1:0]     accept;
    logic             fifo_wr_en;
    logic [W-1:0]     fifo_data_in;
    logic             fifo_full = 1'b0;
    logic             fifo_almostfull = 1'b0;
    logic             fifo_overflow = 1'b0;
    logic [7:0]       ovf_cnt;
    logic             busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .accept(accept), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
        .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
        .fifo_overflow(fifo_overflow), .ovf_cnt(ovf_cnt), .busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // producer model
    logic [W-1:0] base [N];
    int unsigned  sent [N];
    int unsigned  lim  [N];

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i] = (sent[i] < lim[i]);
            req_data[i*W +: W] = base[i] + W'(sent[i]);
        end
    endtask

    function automatic bit all_sent();
        for (int i = 0; i < N; i++) if (sent[i] != lim[i]) return 1'b0;
        return 1'b1;
    endfunction

    logic [N-1:0] s_acc, s_gnt, last_gnt;
    logic         s_wr, s_busy, prev_acc;
    logic [W-1:0] s_data;
    logic [7:0]   s_ovf;
    logic [W-1:0] wr_log[$], exp_wr[$];
    int           gnt_log[$], exp_gnt[$];
    int           onehot_bad, af_bad;

    task automatic cycle();
        @(negedge clk);
        s_acc = accept; s_gnt = gnt; s_wr = fifo_wr_en; s_data = fifo_data_in;
        s_ovf = ovf_cnt; s_busy = busy;
        if (!rst) check("wr_trail", s_wr, prev_acc);
        prev_acc = rst ? 1'b0 : |s_acc;
        if (s_wr) wr_log.push_back(s_data);
        if ($countones(s_gnt) > 1) onehot_bad++;
        if (s_gnt != '0 && s_gnt != last_gnt)
            for (int i = 0; i < N; i++) if (s_gnt[i]) gnt_log.push_back(i);
        last_gnt = s_gnt;
        if (fifo_almostfull && |s_acc && s_wr) af_bad++;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) if (s_acc[i]) sent[i]++;
        drive();
    endtask

    task automatic run_done(input string tag, input int maxc);
        int  c;
        bit  done;
        c = 0; done = 1'b0;
        while (!done && c < maxc) begin
            cycle();
            c++;
            done = all_sent() && !s_busy && !s_wr;
        end
        check({tag, "_done"}, done, 1);
    endtask

    task automatic check_logs(input string tag);
        check({tag, "_nwr"}, wr_log.size(), exp_wr.size());
        for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_wr[i]);
        check({tag, "_ngnt"}, gnt_log.size(), exp_gnt.size());
        for (int i = 0; i < gnt_log.size() && i < exp_gnt.size(); i++)
            check($sformatf("%s_gnt%0d", tag, i), gnt_log[i], exp_gnt[i]);
        check({tag, "_onehot"}, onehot_bad, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo_full = 1'b0; fifo_almostfull = 1'b0; fifo_overflow = 1'b0;
        for (int i = 0; i < N; i++) begin sent[i] = 0; lim[i] = 0; base[i] = '0; end
        drive();
        @(posedge clk); #1;
        check("rst_gnt", gnt, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_data", fifo_data_in, 0);
        check("rst_ovf", ovf_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_accept", accept, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        prev_acc = 1'b0; last_gnt = '0; onehot_bad = 0; af_bad = 0;
        wr_log.delete(); exp_wr.delete(); gnt_log.delete(); exp_gnt.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int eg [10];
        int ew [10];
        int c;

        // single requester, six words
        do_reset();
        base[0] = 16'h00A0; lim[0] = 6; drive();
        eg = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
        ew = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 0};
        for (int k = 0; k < 10; k++) begin
            cycle();
            check($sformatf("t1_gnt_c%0d", k), s_gnt, eg[k]);
            check($sformatf("t1_wr_c%0d", k), s_wr, ew[k]);
        end
        for (int j = 0; j < 6; j++) exp_wr.push_back(16'h00A0 + 16'(j));
        exp_gnt = '{0, 0};
        check_logs("t1");

        // all four continuously
        do_reset();
        for (int i = 0; i < N; i++) begin base[i] = 16'((i + 1) << 12); lim[i] = 8; end
        drive();
        run_done("t2", 200);
        for (int g = 0; g < 8; g++) begin
            exp_gnt.push_back(g % 4);
            for (int j = 0; j < 4; j++)
                exp_wr.push_back(16'(((g % 4) + 1) << 12) + 16'(4 * (g / 4) + j));
        end
        check_logs("t2");

        // requester drop and rotation
        do_reset();
        base[0] = 16'h2000; base[1] = 16'h2100; base[2] = 16'h2200; base[3] = 16'h2300;
        lim[2] = 2; drive();
        run_done("t3a", 50);
        lim[0] = 1; lim[3] = 1; drive();
        run_done("t3b", 50);
        lim[2] = 4; drive();
        run_done("t3c", 50);
        lim[0] = 2; lim[1] = 1; drive();
        run_done("t3d", 50);
        exp_gnt = '{2, 3, 0, 2, 0, 1};
        exp_wr  = '{16'h2200, 16'h2201, 16'h2300, 16'h2000, 16'h2202, 16'h2203,
                    16'h2001, 16'h2100};
        check_logs("t3");

        // full mid-burst
        do_reset();
        base[1] = 16'h00B0; lim[1] = 4; drive();
        repeat (3) cycle();
        fifo_full = 1'b1;
        cycle();
        check("t4_full_acc", s_acc, 0);
        check("t4_full_wr_inflight", s_wr, 1);
        check("t4_full_gnt", s_gnt, 4'b0010);
        cycle();
        check("t4_stall_wr", s_wr, 0);
        check("t4_stall_gnt", s_gnt, 4'b0010);
        check("t4_stall_busy", s_busy, 1);
        cycle();
        fifo_full = 1'b0;
        run_done("t4a", 50);
        exp_wr  = '{16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3};
        exp_gnt = '{1};
        check_logs("t4a");

        // almostfull held
        do_reset();
        base[3] = 16'h3300; lim[3] = 3; fifo_almostfull = 1'b1; drive();
        run_done("t4b", 50);
        fifo_almostfull = 1'b0;
        check("t4b_af_overlap", af_bad, 0);
        exp_wr  = '{16'h3300, 16'h3301, 16'h3302};
        exp_gnt = '{3};
        check_logs("t4b");

        // overflow counter saturation
        do_reset();
        fifo_overflow = 1'b1;
        c = 0;
        repeat (101) begin cycle(); c++; end
        check("t5_ovf_100", s_ovf, 100);
        while (c < 256) begin cycle(); c++; end
        check("t5_ovf_255", s_ovf, 255);
        while (c < 300) begin cycle(); c++; end
        check("t5_ovf_hold", s_ovf, 255);
        fifo_overflow = 1'b0;
        repeat (3) cycle();
        check("t5_ovf_after", s_ovf, 255);

        // reset during the third accept of a burst
        do_reset();
        base[0] = 16'h00C0; base[1] = 16'h00D0; lim[0] = 1; lim[1] = 6; drive();
        c = 0;
        while (sent[1] < 2 && c < 40) begin cycle(); c++; end
        check("t6_reach", sent[1], 2);
        #2;
        check("t6_acc3", accept, 4'b0010);
        rst = 1'b1;
        #1;
        check("t6_rst_gnt", gnt, 0);
        check("t6_rst_wr_en", fifo_wr_en, 0);
        check("t6_rst_data", fifo_data_in, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_accept", accept, 0);
        lim[0] = 3; drive();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; prev_acc = 1'b0; last_gnt = '0;
        run_done("t6", 100);
        exp_gnt = '{0, 1, 0, 1};
        exp_wr  = '{16'h00C0, 16'h00D0, 16'h00C1, 16'h00C2, 16'h00D2, 16'h00D3,
                    16'h00D4, 16'h00D5};
        check_logs("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the sync FIFO among NUM_REQ producers.
- Grants one producer at a time for a bounded burst.
- Drives the FIFO's wr_en/data_in from registers and throttles on full/almostfull.
- Counts FIFO overflow pulses for debug.
- Sits between the producer blocks and the FIFO's DUT-side write inputs.

Parameters:
- NUM_REQ, 4, number of requesting producers (2..8).
- FIFO_WIDTH, 16, data width; must match the FIFO.
- MAX_BURST, 4, maximum accepted words per grant before forced rotation (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-producer request; held high while data is valid.
- req_data  in  NUM_REQ*FIFO_WIDTH  producer data; slice i belongs to producer i.
- gnt  out  NUM_REQ  one-hot registered grant.
- accept  out  NUM_REQ  combinational; producer i's current word is taken this cycle.
- fifo_wr_en  out  1  registered write enable to the FIFO.
- fifo_data_in  out  FIFO_WIDTH  registered write data to the FIFO.
- fifo_full  in  1  FIFO full flag.
- fifo_almostfull  in  1  FIFO almostfull flag.
- fifo_overflow  in  1  FIFO overflow pulse.
- ovf_cnt  out  8  saturating count of fifo_overflow cycles.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset values: gnt=0, fifo_wr_en=0, fifo_data_in=0, ovf_cnt=0, busy=0, state=IDLE, rr_ptr=0, burst_cnt=0.
- States: IDLE, BURST, STALL.
- stall_cond = fifo_full | (fifo_almostfull & fifo_wr_en). This covers the write already in flight, because the registered wr_en lags accept by one cycle.
- IDLE:
  - If any req is high, the winner is the first set req at or after index rr_ptr, wrapping modulo NUM_REQ.
  - Next cycle: gnt = onehot(winner), burst_cnt=0, state=BURST.
  - Nothing is accepted in IDLE; grant latency from req is 1 cycle.
- BURST, winner w:
  - accept[w] = gnt[w] & req[w] & ~stall_cond. All other accept bits are 0.
  - On accept: next cycle fifo_wr_en=1, fifo_data_in=req_data[w]; burst_cnt increments. With no accept, next fifo_wr_en=0.
  - Exit to IDLE when accept occurs with burst_cnt==MAX_BURST-1, or when req[w]==0. On exit: gnt=0, rr_ptr=(w+1) mod NUM_REQ.
  - If req[w] is high and stall_cond is high, go to STALL; gnt is held.
- STALL:
  - accept=0, fifo_wr_en=0 next cycle, gnt held, burst_cnt held.
  - Return to BURST when stall_cond==0.
  - If req[w] drops, go to IDLE with the same rotation as a BURST exit.
- Fairness: each producer gets at most MAX_BURST words per grant. Worst-case wait is (NUM_REQ-1)*(MAX_BURST+1) non-stalled cycles.
- Producer contract: req_data stays stable until accept. A producer may drop req at any time; a dropped req never gets an accept.
- ovf_cnt: +1 per cycle with fifo_overflow=1, saturating at 255. It is not cleared except by rst.
- Reset mid-burst: everything returns to reset values immediately (asynchronous). A registered write in flight is dropped (fifo_wr_en forced to 0).
- No combinational path from fifo_* inputs to fifo_wr_en. accept is the only combinational output.

Test Plan:
- Single requester: req=4'b0001, data 0xA0..0xA5, FIFO empty -> gnt=0001 one cycle after req; accepts 0xA0–0xA3; gnt drops for 1 IDLE cycle; re-grant; 0xA4, 0xA5 written in order. fifo_wr_en trails each accept by exactly 1 cycle.
- All four requesting continuously, MAX_BURST=4 -> grant order 0,1,2,3,0; each grant carries exactly 4 writes; no two gnt bits ever high together.
- Requester 2 drops req after 2 accepts -> state returns to IDLE; rr_ptr=3; next grant goes to 3 if requesting, else wraps to 0.
- FIFO fills (fifo_full=1) mid-burst -> accept=0 and fifo_wr_en=0 within 1 cycle; gnt held; when fifo_full deasserts, writes resume with the next word; no data lost or duplicated; fifo_overflow never asserts.
- Force fifo_overflow high for 300 cycles -> ovf_cnt saturates at 255 and does not wrap.
- Assert rst during the 3rd accept of a burst -> all outputs are 0 within the same cycle; after release, arbitration restarts at producer 0.
